// File: rtl/reconfig_image_ctrl_if.sv
// Device-side reconfiguration bus: the controller drives the enable/trigger/select lines,
// and the device returns an asynchronous error flag.
interface reconfig_image_ctrl_if #(
   parameter int unsigned CBSEL_W = 2
);
   logic               cfg_ENA;
   logic               cfg_CONFIG;
   logic [CBSEL_W-1:0] cfg_CBSEL;
   logic               cfg_ERROR;

   modport master (
      output cfg_ENA,
      output cfg_CONFIG,
      output cfg_CBSEL,
      input  cfg_ERROR
   );

   modport slave (
      input  cfg_ENA,
      input  cfg_CONFIG,
      input  cfg_CBSEL,
      output cfg_ERROR
   );
endinterface

// File: rtl/reconfig_image_ctrl.sv
// Reconfiguration sequencer: SETUP/PULSE/WAIT per attempt, retries, then golden-image fallback.
// Optional IDLE watchdog compiled in with `define RECONFIG_WATCHDOG_EN.
module reconfig_image_ctrl #(
   parameter int unsigned CBSEL_W    = 2,
   parameter int unsigned GOLDEN_IMG = 0,
   parameter int unsigned SETUP_CYC  = 16,
   parameter int unsigned PULSE_CYC  = 8,
   parameter int unsigned TMO_CYC    = 1024,
   parameter int unsigned MAX_RETRY  = 2,
   parameter int unsigned WDT_CYC    = 65536,
   localparam int unsigned RC_W      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  req,
   input  logic [CBSEL_W-1:0]    req_img,
   input  logic                  wdt_kick,
   reconfig_image_ctrl_if.master cfg,
   output logic                  busy,
   output logic                  fault,
   output logic [RC_W-1:0]       retry_cnt
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] SETUP = 3'd1;
   localparam logic [2:0] PULSE = 3'd2;
   localparam logic [2:0] WAIT  = 3'd3;
   localparam logic [2:0] FAULT = 3'd4;

   localparam int unsigned CNT_MAX_A = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
   localparam int unsigned CNT_MAX   = (CNT_MAX_A > TMO_CYC) ? CNT_MAX_A : TMO_CYC;
   localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

   localparam logic [CBSEL_W-1:0] GOLD = CBSEL_W'(GOLDEN_IMG);

   logic [2:0]         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CBSEL_W-1:0] target_q, target_d;
   logic [RC_W-1:0]    rc_q, rc_d;
   logic               err_meta_q, err_sync_q;
   logic               ena_q, ena_d;
   logic               config_q, config_d;
   logic [CBSEL_W-1:0] cbsel_q, cbsel_d;
   logic               busy_q, busy_d;
   logic               fault_q, fault_d;
   logic               start;
   logic [CBSEL_W-1:0] start_img;

`ifdef RECONFIG_WATCHDOG_EN
   localparam int unsigned WDT_W = $clog2(WDT_CYC + 1);

   logic [WDT_W-1:0] wdt_q, wdt_d;
   logic             wdt_fire;

   // A kick in the same cycle as expiry restarts the count instead of firing.
   always_comb begin
      wdt_fire = (state_q == IDLE) && !wdt_kick && (wdt_q == WDT_W'(WDT_CYC - 1));
      if (state_q != IDLE || wdt_kick || wdt_fire) begin
         wdt_d = '0;
      end else begin
         wdt_d = wdt_q + WDT_W'(1);
      end
      start     = req | wdt_fire;
      start_img = wdt_fire ? GOLD : req_img;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wdt_q <= '0;
      end else begin
         wdt_q <= wdt_d;
      end
   end
`else
   logic unused_wdt;
   assign unused_wdt = wdt_kick ^ (WDT_CYC == 0);

   always_comb begin
      start     = req;
      start_img = req_img;
   end
`endif

   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      rc_d     = rc_q;
      cnt_d    = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + CNT_W'(1);

      case (state_q)
         IDLE: begin
            if (start) begin
               target_d = start_img;
               rc_d     = '0;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            if (cnt_q == CNT_W'(SETUP_CYC - 1)) state_d = PULSE;
         end
         PULSE: begin
            if (cnt_q == CNT_W'(PULSE_CYC - 1)) state_d = WAIT;
         end
         WAIT: begin
            if (err_sync_q || cnt_q == CNT_W'(TMO_CYC - 1)) begin
               if (rc_q < RC_W'(MAX_RETRY)) begin
                  rc_d    = rc_q + RC_W'(1);
                  state_d = SETUP;
               end else if (target_q != GOLD) begin
                  target_d = GOLD;
                  rc_d     = '0;
                  state_d  = SETUP;
               end else begin
                  state_d = FAULT;
               end
            end
         end
         FAULT: state_d = FAULT;
         default: state_d = IDLE;
      endcase

      // Every transition changes state, so this also covers WAIT -> SETUP retries.
      if (state_d != state_q) cnt_d = '0;

      ena_d    = state_d inside {SETUP, PULSE, WAIT};
      config_d = (state_d == PULSE);
      busy_d   = (state_d != IDLE);
      fault_d  = (state_d == FAULT);
      if (state_d == FAULT) begin
         cbsel_d = '0;
      end else if (ena_d) begin
         cbsel_d = target_d;
      end else begin
         cbsel_d = cbsel_q;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         err_meta_q <= 1'b0;
         err_sync_q <= 1'b0;
         state_q    <= IDLE;
         cnt_q      <= '0;
         target_q   <= GOLD;
         rc_q       <= '0;
         ena_q      <= 1'b0;
         config_q   <= 1'b0;
         cbsel_q    <= GOLD;
         busy_q     <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         err_meta_q <= cfg.cfg_ERROR;
         err_sync_q <= err_meta_q;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         target_q   <= target_d;
         rc_q       <= rc_d;
         ena_q      <= ena_d;
         config_q   <= config_d;
         cbsel_q    <= cbsel_d;
         busy_q     <= busy_d;
         fault_q    <= fault_d;
      end
   end

   assign cfg.cfg_ENA    = ena_q;
   assign cfg.cfg_CONFIG = config_q;
   assign cfg.cfg_CBSEL  = cbsel_q;
   assign busy           = busy_q;
   assign fault          = fault_q;
   assign retry_cnt      = rc_q;

endmodule
